// File: rtl/qu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents:
//   PC_INCR        byte increment between sequential fetches
//   FE_ADDR_W/FE_INSTR_W  widths of the default fetch_entry_t
//   fetch_entry_t  {pc, instr} pair stored in the fetch buffer
//   if_state_t     fetch control states
package qu_pkg;

  localparam int unsigned PC_INCR    = 4;
  localparam int unsigned FE_ADDR_W  = 32;
  localparam int unsigned FE_INSTR_W = 32;

  typedef struct packed {
    logic [FE_ADDR_W-1:0]  pc;
    logic [FE_INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_RUN,
    IF_DRAIN
  } if_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// Signals:
//   imem_req_valid/ready/addr  request channel to instruction memory
//   imem_rsp_valid/data        in-order response channel, no backpressure
//   id_valid/ready/pc/instr    decode handshake
// Modports:
//   master  fetch stage side
//   slave   memory + decode side
interface instr_fetch_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [ADDR_WIDTH-1:0]  imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   id_valid;
  logic                   id_ready;
  logic [ADDR_WIDTH-1:0]  id_pc;
  logic [INSTR_WIDTH-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_instr,
    output id_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries.
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   push        write push_data (caller guarantees a free slot)
//   push_data   entry to store
//   pop         drop the head entry (ignored when empty)
//   flush       empty the FIFO; wins over push, pop in the same cycle is harmless
//   head        current head entry (registered storage)
//   count       number of stored entries
//   full/empty  occupancy flags
module fetch_buffer
  import qu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !flush;
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= push_data;
    end
  end

  assign head  = r_mem[r_rd];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, in-order instruction memory
// requests, fetch buffering and redirect handling.
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-low reset
//   if_en           fetch enable from the startup controller
//   redirect_valid  branch/exception redirect
//   redirect_pc     redirect target
//   bus             instr_fetch_if.master: imem request/response + decode handshake
// Build option:
//   QU_IF_BYPASS_EN  response goes straight to decode when the buffer is
//                    empty and decode is ready (0-cycle latency)
module instr_fetch
  import qu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned           BUF_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  instr_fetch_if.master         bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  if_state_t             r_state;
  if_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_out;
  logic [CW-1:0]         w_out_nxt;
  logic [ADDR_WIDTH-1:0] r_tag [BUF_DEPTH];
  logic [PW-1:0]         r_tag_wr;
  logic [PW-1:0]         r_tag_rd;

  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_rsp_dec;
  logic                  w_rsp_take;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [CW:0]           w_inflight;
  entry_t                w_push_entry;
  entry_t                w_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;

  // Requests are only issued while every in-flight response is guaranteed
  // a buffer slot.
  assign w_inflight  = {1'b0, r_out} + {1'b0, w_count};
  assign w_req_valid = (r_state == IF_RUN) && if_en && !redirect_valid &&
                       (w_inflight < (CW + 1)'(BUF_DEPTH));
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  // Any response retires a credit; only responses in RUN outside a redirect
  // cycle carry a live instruction.
  assign w_rsp_dec   = bus.imem_rsp_valid && (r_out != '0);
  assign w_rsp_take  = w_rsp_dec && (r_state == IF_RUN) && !redirect_valid;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;

  always_comb begin
    w_out_nxt = r_out;
    unique case ({w_req_fire, w_rsp_dec})
      2'b10:   w_out_nxt = r_out + CW'(1);
      2'b01:   w_out_nxt = r_out - CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IF_IDLE: begin
        if (if_en) w_state_nxt = IF_RUN;
      end
      IF_RUN: begin
        if (redirect_valid) begin
          if (w_out_nxt != '0) w_state_nxt = IF_DRAIN;
          else if (!if_en)     w_state_nxt = IF_IDLE;
        end else if (!if_en && (r_out == '0)) begin
          w_state_nxt = IF_IDLE;
        end
      end
      IF_DRAIN: begin
        if (w_out_nxt == '0) w_state_nxt = if_en ? IF_RUN : IF_IDLE;
      end
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IF_IDLE;
      r_pc    <= RESET_PC;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if (redirect_valid)  r_pc <= redirect_pc;
      else if (w_req_fire) r_pc <= r_pc + ADDR_WIDTH'(PC_INCR);
    end
  end

  // Tag queue: PC of each live in-flight request, popped by its response.
  // Flushed on redirect; responses still outstanding at that point are
  // dropped in DRAIN without touching it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else if (redirect_valid) begin
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      if (w_req_fire) r_tag_wr <= r_tag_wr + PW'(1);
      if (w_rsp_take) r_tag_rd <= r_tag_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag[r_tag_wr] <= r_pc;
  end

  assign w_push_entry = '{pc: r_tag[r_tag_rd], instr: bus.imem_rsp_data};
  assign w_push       = w_rsp_take && !w_bypass && !w_full;
  assign w_pop        = bus.id_valid && bus.id_ready;

  fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

`ifdef QU_IF_BYPASS_EN
  // Empty buffer with decode ready: the response is handed over directly
  // and never stored.
  assign w_bypass     = w_rsp_take && w_empty && bus.id_ready;
  assign bus.id_valid = !w_empty || w_bypass;
  assign bus.id_pc    = w_bypass ? r_tag[r_tag_rd] : w_head.pc;
  assign bus.id_instr = w_bypass ? bus.imem_rsp_data : w_head.instr;
`else
  assign w_bypass     = 1'b0;
  assign bus.id_valid = !w_empty;
  assign bus.id_pc    = w_head.pc;
  assign bus.id_instr = w_head.instr;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        if_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;
  int unsigned lat;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pq[$];

  instr_fetch_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) b ();

  instr_fetch #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000),
    .BUF_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_en          (if_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory returns addr ^ 32'hDEAD_0000.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // One clock: capture the request handshake, advance, then drive the
  // in-order memory response due in the new cycle.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    @(negedge clk);
    fire = b.imem_req_valid && b.imem_req_ready;
    a    = b.imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (fire) pq.push_back('{addr: a, due: cyc - 1 + lat});
    if (pq.size() != 0 && pq[0].due == cyc) begin
      b.imem_rsp_valid = 1'b1;
      b.imem_rsp_data  = mem_data(pq[0].addr);
      void'(pq.pop_front());
    end else begin
      b.imem_rsp_valid = 1'b0;
      b.imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic quiesce(input string tag);
    if_en = 1'b0; redirect_valid = 1'b0; b.id_ready = 1'b1;
    repeat (10) tick();
    total++; if (b.id_valid !== 1'b0 || b.imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL %s_quiesce: id_valid=%b req_valid=%b want 0 0", tag, b.id_valid, b.imem_req_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b0; if_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    b.imem_req_ready = 1'b0; b.id_ready = 1'b0;
    b.imem_rsp_valid = 1'b0; b.imem_rsp_data = '0;
    lat = 1;
    tick(); tick();
    total++; if (b.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got=%b want=0", b.imem_req_valid); end
    total++; if (b.id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid: got=%b want=0", b.id_valid); end
    total++; if (b.id_pc !== 32'h0) begin bad++; $display("FAIL reset_id_pc: got=%h want=0", b.id_pc); end
    total++; if (b.id_instr !== 32'h0) begin bad++; $display("FAIL reset_id_instr: got=%h want=0", b.id_instr); end
    total++; if (b.imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_pc: got=%h want=0", b.imem_req_addr); end
  endtask

  task automatic test_startup();
    rst = 1'b1; if_en = 1'b1; b.imem_req_ready = 1'b1; b.id_ready = 1'b1; lat = 1;
    #1;
    total++; if (b.imem_req_valid !== 1'b0) begin bad++; $display("FAIL startup_idle: req_valid=%b want=0", b.imem_req_valid); end
    tick();
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h0) begin bad++;
      $display("FAIL startup_addr0: valid=%b addr=%h want 1 00000000", b.imem_req_valid, b.imem_req_addr); end
    tick();
    total++; if (b.imem_req_addr !== 32'h4) begin bad++; $display("FAIL startup_addr4: got=%h want=00000004", b.imem_req_addr); end
    total++; if (b.id_valid !== 1'b0) begin bad++; $display("FAIL startup_latency: id_valid=%b want=0", b.id_valid); end
    tick();
    total++; if (b.imem_req_addr !== 32'h8) begin bad++; $display("FAIL startup_addr8: got=%h want=00000008", b.imem_req_addr); end
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h0 || b.id_instr !== 32'hDEAD_0000) begin bad++;
      $display("FAIL startup_id0: valid=%b pc=%h instr=%h want 1 00000000 dead0000", b.id_valid, b.id_pc, b.id_instr); end
    tick();
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h4 || b.id_instr !== 32'hDEAD_0004) begin bad++;
      $display("FAIL startup_id4: valid=%b pc=%h instr=%h want 1 00000004 dead0004", b.id_valid, b.id_pc, b.id_instr); end
    if_en = 1'b0;
    tick();
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h8) begin bad++;
      $display("FAIL startup_id8: valid=%b pc=%h want 1 00000008", b.id_valid, b.id_pc); end
    quiesce("startup");
  endtask

  task automatic test_backpressure();
    int unsigned fires;
    fires = 0;
    b.id_ready = 1'b0; if_en = 1'b1; lat = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b.imem_req_valid && b.imem_req_ready) fires++;
    end
    total++; if (fires !== 4) begin bad++; $display("FAIL bp_req_count: got=%0d want=4", fires); end
    total++; if (b.imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_stall: req_valid=%b want=0", b.imem_req_valid); end
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'hC || b.id_instr !== 32'hDEAD_000C) begin bad++;
      $display("FAIL bp_head: valid=%b pc=%h instr=%h want 1 0000000c dead000c", b.id_valid, b.id_pc, b.id_instr); end
    b.id_ready = 1'b1;
    #1;
    total++; if (b.imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle: req_valid=%b want=0", b.imem_req_valid); end
    tick();
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h1C || b.id_pc !== 32'h10) begin bad++;
      $display("FAIL bp_refill1: valid=%b addr=%h id_pc=%h want 1 0000001c 00000010", b.imem_req_valid, b.imem_req_addr, b.id_pc); end
    tick();
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h20 || b.id_pc !== 32'h14) begin bad++;
      $display("FAIL bp_refill2: valid=%b addr=%h id_pc=%h want 1 00000020 00000014", b.imem_req_valid, b.imem_req_addr, b.id_pc); end
    quiesce("bp");
  endtask

  task automatic test_redirect_drain();
    int unsigned n;
    redirect_valid = 1'b1; redirect_pc = 32'h200; if_en = 1'b0; b.id_ready = 1'b1; lat = 3;
    tick();
    redirect_valid = 1'b0; if_en = 1'b1;
    tick();
    total++; if (b.imem_req_addr !== 32'h200) begin bad++; $display("FAIL drain_setup_addr: got=%h want=00000200", b.imem_req_addr); end
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (b.imem_req_valid !== 1'b0) begin bad++; $display("FAIL drain_redirect_cycle: req_valid=%b want=0", b.imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (b.imem_req_valid !== 1'b0 || b.id_valid !== 1'b0) begin bad++;
      $display("FAIL drain_stale1: req_valid=%b id_valid=%b want 0 0", b.imem_req_valid, b.id_valid); end
    tick();
    total++; if (b.imem_req_valid !== 1'b0 || b.id_valid !== 1'b0) begin bad++;
      $display("FAIL drain_stale2: req_valid=%b id_valid=%b want 0 0", b.imem_req_valid, b.id_valid); end
    tick();
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h100) begin bad++;
      $display("FAIL drain_restart: valid=%b addr=%h want 1 00000100", b.imem_req_valid, b.imem_req_addr); end
    n = 0;
    while (b.id_valid !== 1'b1 && n < 10) begin tick(); n++; end
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h100 || b.id_instr !== 32'hDEAD_0100) begin bad++;
      $display("FAIL drain_first_id: valid=%b pc=%h instr=%h want 1 00000100 dead0100", b.id_valid, b.id_pc, b.id_instr); end
    quiesce("drain");
  endtask

  task automatic test_redirect_full();
    redirect_valid = 1'b1; redirect_pc = 32'h300; if_en = 1'b0; b.id_ready = 1'b0; lat = 1;
    tick();
    redirect_valid = 1'b0; if_en = 1'b1;
    repeat (5) tick();
    b.id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
    #1;
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h300 || b.imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL rfull_head: id_valid=%b id_pc=%h req_valid=%b want 1 00000300 0", b.id_valid, b.id_pc, b.imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (b.id_valid !== 1'b0) begin bad++; $display("FAIL rfull_flushed: id_valid=%b want=0", b.id_valid); end
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h400) begin bad++;
      $display("FAIL rfull_target: valid=%b addr=%h want 1 00000400", b.imem_req_valid, b.imem_req_addr); end
    tick();
    total++; if (b.id_valid !== 1'b0) begin bad++; $display("FAIL rfull_no_stale: id_valid=%b id_pc=%h want valid 0", b.id_valid, b.id_pc); end
    tick();
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h400 || b.id_instr !== 32'hDEAD_0400) begin bad++;
      $display("FAIL rfull_first_id: valid=%b pc=%h instr=%h want 1 00000400 dead0400", b.id_valid, b.id_pc, b.id_instr); end
    quiesce("rfull");
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; if_en = 1'b0; b.id_ready = 1'b1; lat = 1;
    tick();
    redirect_valid = 1'b0; if_en = 1'b1;
    tick();
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL wrap_top: valid=%b addr=%h want 1 fffffffc", b.imem_req_valid, b.imem_req_addr); end
    tick();
    total++; if (b.imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero: got=%h want=00000000", b.imem_req_addr); end
    tick();
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'hFFFF_FFFC || b.id_instr !== 32'h2152_FFFC) begin bad++;
      $display("FAIL wrap_id_top: valid=%b pc=%h instr=%h want 1 fffffffc 2152fffc", b.id_valid, b.id_pc, b.id_instr); end
    tick();
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h0 || b.id_instr !== 32'hDEAD_0000) begin bad++;
      $display("FAIL wrap_id_zero: valid=%b pc=%h instr=%h want 1 00000000 dead0000", b.id_valid, b.id_pc, b.id_instr); end
    quiesce("wrap");
  endtask

  task automatic test_reset_mid_drain();
    redirect_valid = 1'b1; redirect_pc = 32'h500; if_en = 1'b0; b.id_ready = 1'b1; lat = 3;
    tick();
    redirect_valid = 1'b0; if_en = 1'b1;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h600;
    tick();
    redirect_valid = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; if_en = 1'b0;
    #1;
    total++; if (b.imem_req_valid !== 1'b0 || b.id_valid !== 1'b0) begin bad++;
      $display("FAIL rstd_valids: req_valid=%b id_valid=%b want 0 0", b.imem_req_valid, b.id_valid); end
    total++; if (b.id_pc !== 32'h0 || b.id_instr !== 32'h0 || b.imem_req_addr !== 32'h0) begin bad++;
      $display("FAIL rstd_values: id_pc=%h id_instr=%h addr=%h want 0 0 0", b.id_pc, b.id_instr, b.imem_req_addr); end
    repeat (3) tick();
    total++; if (b.id_valid !== 1'b0) begin bad++; $display("FAIL rstd_late_rsp: id_valid=%b id_pc=%h want valid 0", b.id_valid, b.id_pc); end
    lat = 1; if_en = 1'b1;
    tick();
    total++; if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h0) begin bad++;
      $display("FAIL rstd_restart: valid=%b addr=%h want 1 00000000", b.imem_req_valid, b.imem_req_addr); end
    tick();
    tick();
    total++; if (b.id_valid !== 1'b1 || b.id_pc !== 32'h0 || b.id_instr !== 32'hDEAD_0000) begin bad++;
      $display("FAIL rstd_first_id: valid=%b pc=%h instr=%h want 1 00000000 dead0000", b.id_valid, b.id_pc, b.id_instr); end
    quiesce("rstd");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect_drain();
    test_redirect_full();
    test_wrap();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
